stage_ex_muldiv: RTL and testbench

Execute stage for the RV32IM core, generalised over `DATA_WIDTH` and extended with the M-extension. Single-cycle ALU operations and iterative multiply/divide (radix-2, one bit per cycle) share a registered EX/MEM output. The stage uses valid/ready handshakes on both sides, so it stalls the pipeline while a multi-cycle operation runs. It sits between the decode/register-read stage and the memory stage and supports flush on branch mispredict.

---
 rtl/stage_ex_muldiv.sv | 342 ++++++++++++++++++++++++++++++++++
 tb/tb_stage_ex_muldiv.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_ex_muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : stage_ex_muldiv
//  Purpose  : RV32IM-style execute stage. Single-cycle ALU operations and
//             M-extension multiply/divide share one registered EX/MEM output.
//             MUL/MULH* run either combinationally (FAST_MUL=1) or as a
//             radix-2 shift-add loop. DIV/REM always use a radix-2 restoring
//             loop, except for divide-by-zero and signed overflow, which
//             complete in one cycle.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    i_Clock       clock, rising edge
//    i_Reset       asynchronous reset, active low
//    i_Valid       upstream operation valid
//    o_Ready       stage can accept this cycle
//    i_DataA       operand A (rs1 / dividend / multiplicand)
//    i_DataB       operand B (rs2 / divisor / multiplier)
//    i_PC          instruction address carried to the output
//    i_RegDst      destination register carried to the output
//    i_AluControl  ALU op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL,
//                  7 SRA, 8 SLT, 9 SLTU, 10 PASSB (LUI); others give 0
//    i_IsMulDiv    1 selects the M-extension unit
//    i_MulDivOp    funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//    i_Flush       discard in-flight and registered operation
//    o_Valid       output register holds a result
//    i_Ready       downstream accepts the result
//    o_Result      result
//    o_PC          PC of the result
//    o_RegDst      destination of the result
//    o_Busy        multi-cycle operation in progress
// ============================================================================
module stage_ex_muldiv #(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32,
  parameter int REG_WIDTH  = 5,
  parameter int FAST_MUL   = 0
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Valid,
  output logic                  o_Ready,
  input  logic [DATA_WIDTH-1:0] i_DataA,
  input  logic [DATA_WIDTH-1:0] i_DataB,
  input  logic [PC_WIDTH-1:0]   i_PC,
  input  logic [REG_WIDTH-1:0]  i_RegDst,
  input  logic [3:0]            i_AluControl,
  input  logic                  i_IsMulDiv,
  input  logic [2:0]            i_MulDivOp,
  input  logic                  i_Flush,
  output logic                  o_Valid,
  input  logic                  i_Ready,
  output logic [DATA_WIDTH-1:0] o_Result,
  output logic [PC_WIDTH-1:0]   o_PC,
  output logic [REG_WIDTH-1:0]  o_RegDst,
  output logic                  o_Busy
);

  // ALU operation encodings
  localparam logic [3:0] c_ALU_ADD   = 4'd0;
  localparam logic [3:0] c_ALU_SUB   = 4'd1;
  localparam logic [3:0] c_ALU_AND   = 4'd2;
  localparam logic [3:0] c_ALU_OR    = 4'd3;
  localparam logic [3:0] c_ALU_XOR   = 4'd4;
  localparam logic [3:0] c_ALU_SLL   = 4'd5;
  localparam logic [3:0] c_ALU_SRL   = 4'd6;
  localparam logic [3:0] c_ALU_SRA   = 4'd7;
  localparam logic [3:0] c_ALU_SLT   = 4'd8;
  localparam logic [3:0] c_ALU_SLTU  = 4'd9;
  localparam logic [3:0] c_ALU_PASSB = 4'd10;

  localparam int c_SHW = $clog2(DATA_WIDTH);
  localparam int c_CW  = $clog2(DATA_WIDTH);
  localparam logic [c_CW-1:0]       c_LAST = c_CW'(DATA_WIDTH - 1);
  localparam logic [c_CW-1:0]       c_ONE  = c_CW'(1);
  localparam logic [DATA_WIDTH-1:0] c_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic                  c_FAST = (FAST_MUL != 0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MUL_RUN = 2'd1,
    S_DIV_RUN = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                    r_State;
  logic [c_CW-1:0]           r_Count;
  logic                      r_Valid;
  logic                      r_Busy;
  logic [DATA_WIDTH-1:0]     r_Result;
  logic [PC_WIDTH-1:0]       r_OutPC;
  logic [REG_WIDTH-1:0]      r_OutRegDst;

  // Operation context captured at accept for the iterative paths
  logic [PC_WIDTH-1:0]       r_PC;
  logic [REG_WIDTH-1:0]      r_RegDst;
  logic [2:0]                r_Op;
  logic                      r_NegQ;     // negate product / quotient
  logic                      r_NegR;     // negate remainder
  logic [2*DATA_WIDTH-1:0]   r_MulP;     // {partial sum, remaining multiplier}
  logic [DATA_WIDTH-1:0]     r_Mcand;
  logic [DATA_WIDTH-1:0]     r_DivQ;
  logic [DATA_WIDTH-1:0]     r_DivR;
  logic [DATA_WIDTH-1:0]     r_Divisor;

  logic                      w_Accept;
  logic                      w_IsMul;
  logic                      w_IsDiv;
  logic                      w_ASigned;
  logic                      w_BSigned;
  logic                      w_ANeg;
  logic                      w_BNeg;
  logic [DATA_WIDTH-1:0]     w_AMag;
  logic [DATA_WIDTH-1:0]     w_BMag;
  logic                      w_DivZero;
  logic                      w_Ovf;
  logic                      w_Special;
  logic [DATA_WIDTH-1:0]     w_SpecialRes;
  logic [2*DATA_WIDTH-1:0]   w_FastProd;
  logic [DATA_WIDTH-1:0]     w_FastMulRes;
  logic [DATA_WIDTH-1:0]     w_AluRes;
  logic [DATA_WIDTH-1:0]     w_QuickRes;
  logic                      w_Quick;
  logic [c_SHW-1:0]          w_Shamt;
  logic [DATA_WIDTH:0]       w_MulSum;
  logic [DATA_WIDTH:0]       w_DivShift;
  logic                      w_DivGe;
  logic [DATA_WIDTH-1:0]     w_DivSub;
  logic [2*DATA_WIDTH-1:0]   w_MulFinal;
  logic [DATA_WIDTH-1:0]     w_QFinal;
  logic [DATA_WIDTH-1:0]     w_RFinal;
  logic [DATA_WIDTH-1:0]     w_LongRes;

  // Ready depends on i_Ready (output can drain this cycle) but never on i_Valid
  assign o_Ready  = (r_State == S_IDLE) & (~r_Valid | i_Ready);
  assign w_Accept = i_Valid & o_Ready;

  assign o_Valid  = r_Valid;
  assign o_Busy   = r_Busy;
  assign o_Result = r_Result;
  assign o_PC     = r_OutPC;
  assign o_RegDst = r_OutRegDst;

  // ---------------------------------------------------------------------------
  // Operand decode
  // ---------------------------------------------------------------------------
  assign w_IsMul   = i_IsMulDiv & ~i_MulDivOp[2];
  assign w_IsDiv   = i_IsMulDiv &  i_MulDivOp[2];
  // A is signed for MULH, MULHSU, DIV, REM; B for MULH, DIV, REM.
  // MUL keeps only the low half, which is the same for any signedness.
  assign w_ASigned = (i_MulDivOp == 3'b001) | (i_MulDivOp == 3'b010) |
                     (i_MulDivOp == 3'b100) | (i_MulDivOp == 3'b110);
  assign w_BSigned = (i_MulDivOp == 3'b001) | (i_MulDivOp == 3'b100) |
                     (i_MulDivOp == 3'b110);
  assign w_ANeg    = w_ASigned & i_DataA[DATA_WIDTH-1];
  assign w_BNeg    = w_BSigned & i_DataB[DATA_WIDTH-1];
  assign w_AMag    = w_ANeg ? -i_DataA : i_DataA;
  assign w_BMag    = w_BNeg ? -i_DataB : i_DataB;

  // Division corner cases resolved at accept without iterating
  assign w_DivZero = (i_DataB == '0);
  assign w_Ovf     = ~i_MulDivOp[0] & (i_DataA == c_MIN) & (i_DataB == '1);
  assign w_Special = w_IsDiv & (w_DivZero | w_Ovf);
  assign w_SpecialRes = w_DivZero ? (i_MulDivOp[1] ? i_DataA : '1)
                                  : (i_MulDivOp[1] ? '0 : i_DataA);

  // ---------------------------------------------------------------------------
  // Optional single-cycle multiplier: extending both operands to 2W bits with
  // their own signedness makes the low 2W product bits exact for every MUL*.
  // ---------------------------------------------------------------------------
  generate
    if (FAST_MUL != 0) begin : g_fast_mul
      logic [2*DATA_WIDTH-1:0] w_AExt;
      logic [2*DATA_WIDTH-1:0] w_BExt;
      assign w_AExt     = {{DATA_WIDTH{w_ANeg}}, i_DataA};
      assign w_BExt     = {{DATA_WIDTH{w_BNeg}}, i_DataB};
      assign w_FastProd = w_AExt * w_BExt;
    end else begin : g_iter_mul
      assign w_FastProd = '0;
    end
  endgenerate

  assign w_FastMulRes = (i_MulDivOp[1:0] == 2'b00) ? w_FastProd[DATA_WIDTH-1:0]
                                                   : w_FastProd[2*DATA_WIDTH-1:DATA_WIDTH];

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  assign w_Shamt = i_DataB[c_SHW-1:0];

  always_comb begin
    w_AluRes = '0;
    case (i_AluControl)
      c_ALU_ADD:   w_AluRes = i_DataA + i_DataB;
      c_ALU_SUB:   w_AluRes = i_DataA - i_DataB;
      c_ALU_AND:   w_AluRes = i_DataA & i_DataB;
      c_ALU_OR:    w_AluRes = i_DataA | i_DataB;
      c_ALU_XOR:   w_AluRes = i_DataA ^ i_DataB;
      c_ALU_SLL:   w_AluRes = i_DataA << w_Shamt;
      c_ALU_SRL:   w_AluRes = i_DataA >> w_Shamt;
      c_ALU_SRA:   w_AluRes = $signed(i_DataA) >>> w_Shamt;
      c_ALU_SLT:   w_AluRes = {{(DATA_WIDTH-1){1'b0}}, ($signed(i_DataA) < $signed(i_DataB))};
      c_ALU_SLTU:  w_AluRes = {{(DATA_WIDTH-1){1'b0}}, (i_DataA < i_DataB)};
      c_ALU_PASSB: w_AluRes = i_DataB;
      default:     w_AluRes = '0;
    endcase
  end

  // Result for anything that completes at the accept edge
  assign w_Quick = ~i_IsMulDiv | (w_IsMul & c_FAST) | w_Special;

  always_comb begin
    w_QuickRes = w_AluRes;
    if (i_IsMulDiv) begin
      w_QuickRes = i_MulDivOp[2] ? w_SpecialRes : w_FastMulRes;
    end
  end

  // ---------------------------------------------------------------------------
  // Iteration datapath
  // ---------------------------------------------------------------------------
  // Shift-add: add the multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole product right by one,
  // keeping the carry out of the addition as the new MSB.
  assign w_MulSum = {1'b0, r_MulP[2*DATA_WIDTH-1:DATA_WIDTH]} +
                    (r_MulP[0] ? {1'b0, r_Mcand} : '0);

  // Restoring division: the shifted partial remainder needs one extra bit,
  // but after a successful subtract it is below the divisor again, so the
  // difference fits in DATA_WIDTH bits.
  assign w_DivShift = {r_DivR, r_DivQ[DATA_WIDTH-1]};
  assign w_DivGe    = (w_DivShift >= {1'b0, r_Divisor});
  assign w_DivSub   = w_DivShift[DATA_WIDTH-1:0] - r_Divisor;

  assign w_MulFinal = r_NegQ ? -r_MulP : r_MulP;
  assign w_QFinal   = r_NegQ ? -r_DivQ : r_DivQ;
  assign w_RFinal   = r_NegR ? -r_DivR : r_DivR;
  assign w_LongRes  = r_Op[2] ? (r_Op[1] ? w_RFinal : w_QFinal)
                              : ((r_Op[1:0] == 2'b00) ? w_MulFinal[DATA_WIDTH-1:0]
                                                      : w_MulFinal[2*DATA_WIDTH-1:DATA_WIDTH]);

  // ---------------------------------------------------------------------------
  // Control FSM and registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      r_State     <= S_IDLE;
      r_Count     <= '0;
      r_Valid     <= 1'b0;
      r_Busy      <= 1'b0;
      r_Result    <= '0;
      r_OutPC     <= '0;
      r_OutRegDst <= '0;
      r_PC        <= '0;
      r_RegDst    <= '0;
      r_Op        <= '0;
      r_NegQ      <= 1'b0;
      r_NegR      <= 1'b0;
      r_MulP      <= '0;
      r_Mcand     <= '0;
      r_DivQ      <= '0;
      r_DivR      <= '0;
      r_Divisor   <= '0;
    end else if (i_Flush) begin
      // Flush wins over any accept or completion in the same cycle
      r_State <= S_IDLE;
      r_Count <= '0;
      r_Valid <= 1'b0;
      r_Busy  <= 1'b0;
    end else begin
      // Busy trails the RUN states by one edge
      r_Busy <= (r_State == S_MUL_RUN) | (r_State == S_DIV_RUN);

      // Result consumed; a new write later in this block takes precedence
      if (r_Valid & i_Ready) begin
        r_Valid <= 1'b0;
      end

      case (r_State)
        S_IDLE: begin
          if (w_Accept) begin
            if (w_Quick) begin
              r_Valid     <= 1'b1;
              r_Result    <= w_QuickRes;
              r_OutPC     <= i_PC;
              r_OutRegDst <= i_RegDst;
            end else begin
              r_PC      <= i_PC;
              r_RegDst  <= i_RegDst;
              r_Op      <= i_MulDivOp;
              r_NegQ    <= w_ANeg ^ w_BNeg;
              r_NegR    <= w_ANeg;
              r_Mcand   <= w_AMag;
              r_MulP    <= {{DATA_WIDTH{1'b0}}, w_BMag};
              r_DivQ    <= w_AMag;
              r_DivR    <= '0;
              r_Divisor <= w_BMag;
              r_Count   <= '0;
              r_State   <= w_IsMul ? S_MUL_RUN : S_DIV_RUN;
            end
          end
        end

        S_MUL_RUN: begin
          r_MulP <= {w_MulSum, r_MulP[DATA_WIDTH-1:1]};
          if (r_Count == c_LAST) begin
            r_Count <= '0;
            r_State <= S_DONE;
          end else begin
            r_Count <= r_Count + c_ONE;
          end
        end

        S_DIV_RUN: begin
          r_DivQ <= {r_DivQ[DATA_WIDTH-2:0], w_DivGe};
          r_DivR <= w_DivGe ? w_DivSub : w_DivShift[DATA_WIDTH-1:0];
          if (r_Count == c_LAST) begin
            r_Count <= '0;
            r_State <= S_DONE;
          end else begin
            r_Count <= r_Count + c_ONE;
          end
        end

        S_DONE: begin
          // Hold off until the output register is free
          if (~r_Valid | i_Ready) begin
            r_Valid     <= 1'b1;
            r_Result    <= w_LongRes;
            r_OutPC     <= r_PC;
            r_OutRegDst <= r_RegDst;
            r_State     <= S_IDLE;
          end
        end

        default: r_State <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stage_ex_muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stage_ex_muldiv
//  Purpose  : Directed self-checking bench for stage_ex_muldiv. One instance
//             uses the iterative multiplier, a second uses FAST_MUL=1.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stage_ex_muldiv;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, OR_ = 4'd3, XOR_ = 4'd4,
                         SRA = 4'd7, SLT = 4'd8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_s, valid_f;
  logic [31:0] data_a, data_b, pc;
  logic [4:0]  regdst;
  logic [3:0]  aluc;
  logic        ismd;
  logic [2:0]  mdop;
  logic        flush;
  logic        dready;

  logic        s_ready, s_valid, s_busy;
  logic [31:0] s_result, s_pc;
  logic [4:0]  s_regdst;
  logic        f_ready, f_valid, f_busy;
  logic [31:0] f_result, f_pc;
  logic [4:0]  f_regdst;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  stage_ex_muldiv #(.DATA_WIDTH(32), .PC_WIDTH(32), .REG_WIDTH(5), .FAST_MUL(0)) u_slow (
    .i_Clock(clk), .i_Reset(rst_n), .i_Valid(valid_s), .o_Ready(s_ready),
    .i_DataA(data_a), .i_DataB(data_b), .i_PC(pc), .i_RegDst(regdst),
    .i_AluControl(aluc), .i_IsMulDiv(ismd), .i_MulDivOp(mdop), .i_Flush(flush),
    .o_Valid(s_valid), .i_Ready(dready), .o_Result(s_result), .o_PC(s_pc),
    .o_RegDst(s_regdst), .o_Busy(s_busy)
  );

  stage_ex_muldiv #(.DATA_WIDTH(32), .PC_WIDTH(32), .REG_WIDTH(5), .FAST_MUL(1)) u_fast (
    .i_Clock(clk), .i_Reset(rst_n), .i_Valid(valid_f), .o_Ready(f_ready),
    .i_DataA(data_a), .i_DataB(data_b), .i_PC(pc), .i_RegDst(regdst),
    .i_AluControl(aluc), .i_IsMulDiv(ismd), .i_MulDivOp(mdop), .i_Flush(flush),
    .o_Valid(f_valid), .i_Ready(dready), .o_Result(f_result), .o_PC(f_pc),
    .o_RegDst(f_regdst), .o_Busy(f_busy)
  );

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  // Present one operation to the iterative instance (called at a negedge)
  task automatic drive(input logic md, input logic [2:0] op, input logic [3:0] alu,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic [4:0] rd);
    ismd = md; mdop = op; aluc = alu; data_a = a; data_b = b; pc = p; regdst = rd;
    valid_s = 1'b1;
  endtask

  // Single-cycle op on the iterative instance: result visible after accept edge
  task automatic run_quick(input string tag, input logic md, input logic [2:0] op,
                           input logic [3:0] alu, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
    drive(md, op, alu, a, b, 32'h0000_0400, 5'd4);
    @(negedge clk);
    valid_s = 1'b0;
    check1({tag, "_valid"}, s_valid, 1'b1);
    check32(tag, s_result, exp);
  endtask

  // Iterative op: wait (bounded) for the result
  task automatic run_long(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
    int k;
    drive(1'b1, op, ADD, a, b, 32'h0000_0600, 5'd6);
    @(negedge clk);
    valid_s = 1'b0;
    k = 0;
    while (!s_valid && k < 60) begin
      @(negedge clk);
      k++;
    end
    check1({tag, "_valid"}, s_valid, 1'b1);
    check32(tag, s_result, exp);
  endtask

  initial begin
    int j, busy_cnt, ready_hi, bad, stray;
    logic [31:0] held;

    rst_n = 1'b0; valid_s = 1'b0; valid_f = 1'b0; flush = 1'b0; dready = 1'b1;
    data_a = '0; data_b = '0; pc = '0; regdst = '0; aluc = '0; ismd = 1'b0; mdop = '0;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    check1("rst_valid", s_valid, 1'b0);
    check32("rst_result", s_result, 32'h0);
    check32("rst_pc", s_pc, 32'h0);
    check32("rst_regdst", {27'd0, s_regdst}, 32'h0);
    check1("rst_busy", s_busy, 1'b0);
    check1("rst_ready", s_ready, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- ADD 5 + 7, then back-to-back ALU ops, one result per cycle ----
    drive(1'b0, 3'b000, ADD, 32'd5, 32'd7, 32'h0000_0100, 5'd3);
    @(negedge clk);
    check1("add_valid", s_valid, 1'b1);
    check32("add_result", s_result, 32'd12);
    check32("add_pc", s_pc, 32'h0000_0100);
    check32("add_regdst", {27'd0, s_regdst}, 32'd3);
    drive(1'b0, 3'b000, SUB, 32'd10, 32'd3, 32'h0000_0104, 5'd4);
    @(negedge clk);
    check1("b2b_sub_valid", s_valid, 1'b1);
    check32("b2b_sub", s_result, 32'd7);
    drive(1'b0, 3'b000, XOR_, 32'h0000_00F0, 32'h0000_00FF, 32'h0000_0108, 5'd5);
    @(negedge clk);
    check1("b2b_xor_valid", s_valid, 1'b1);
    check32("b2b_xor", s_result, 32'h0000_000F);
    drive(1'b0, 3'b000, SLT, 32'hFFFF_FFFF, 32'd1, 32'h0000_010C, 5'd6);
    @(negedge clk);
    check1("b2b_slt_valid", s_valid, 1'b1);
    check32("b2b_slt", s_result, 32'd1);
    drive(1'b0, 3'b000, SRA, 32'h8000_0000, 32'd4, 32'h0000_0110, 5'd7);
    @(negedge clk);
    valid_s = 1'b0;
    check1("b2b_sra_valid", s_valid, 1'b1);
    check32("b2b_sra", s_result, 32'hF800_0000);
    check32("b2b_sra_pc", s_pc, 32'h0000_0110);
    @(negedge clk);
    check1("valid_falls", s_valid, 1'b0);

    // ---- MULH 0x80000000 * 0x80000000, iterative ----
    // j counts edges after the accept edge; busy after edges 1..32,
    // result after edge 33, ready low the whole time.
    drive(1'b1, 3'b001, ADD, 32'h8000_0000, 32'h8000_0000, 32'h0000_0200, 5'd8);
    @(negedge clk);
    valid_s = 1'b0;
    j = 0; busy_cnt = 0; ready_hi = 0;
    while (!s_valid && j < 60) begin
      if (s_busy) busy_cnt++;
      if (s_ready) ready_hi++;
      @(negedge clk);
      j++;
    end
    check32("mulh_latency", 32'(j), 32'd33);
    check32("mulh_busy_cycles", 32'(busy_cnt), 32'd32);
    check32("mulh_ready_high_cycles", 32'(ready_hi), 32'd0);
    check32("mulh_result", s_result, 32'h4000_0000);
    check32("mulh_pc", s_pc, 32'h0000_0200);
    check32("mulh_regdst", {27'd0, s_regdst}, 32'd8);
    @(negedge clk);

    // ---- same MULH on the FAST_MUL instance: one cycle ----
    valid_f = 1'b1;
    @(negedge clk);
    valid_f = 1'b0;
    check1("fast_mulh_valid", f_valid, 1'b1);
    check32("fast_mulh", f_result, 32'h4000_0000);
    check1("fast_mulh_busy", f_busy, 1'b0);
    @(negedge clk);

    // ---- iterative divide / remainder ----
    run_long("div_neg7_2",  3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_long("rem_neg7_2",  3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_long("divu_100_7",  3'b101, 32'd100, 32'd7, 32'd14);
    run_long("remu_100_7",  3'b111, 32'd100, 32'd7, 32'd2);
    run_long("mulhu_ffff",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_long("mulhsu_neg1", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
    @(negedge clk);

    // ---- division special cases: one cycle each ----
    run_quick("div_by_zero",  1'b1, 3'b100, ADD, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_quick("rem_by_zero",  1'b1, 3'b110, ADD, 32'd5, 32'd0, 32'd5);
    run_quick("divu_by_zero", 1'b1, 3'b101, ADD, 32'd9, 32'd0, 32'hFFFF_FFFF);
    run_quick("div_ovf",      1'b1, 3'b100, ADD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_quick("rem_ovf",      1'b1, 3'b110, ADD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    @(negedge clk);

    // ---- flush during DIVU at iteration 10 ----
    drive(1'b1, 3'b101, ADD, 32'd1000, 32'd3, 32'h0000_0700, 5'd12);
    @(negedge clk);
    valid_s = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check1("flush_ready", s_ready, 1'b1);
    check1("flush_valid", s_valid, 1'b0);
    check1("flush_busy", s_busy, 1'b0);
    run_quick("post_flush_add", 1'b0, 3'b000, ADD, 32'd2, 32'd3, 32'd5);
    stray = 0;
    repeat (40) begin
      @(negedge clk);
      if (s_valid) stray++;
    end
    check32("flush_no_late_result", 32'(stray), 32'd0);

    // ---- flush overrides a same-cycle accept ----
    drive(1'b0, 3'b000, ADD, 32'd1, 32'd1, 32'h0000_0800, 5'd13);
    flush = 1'b1;
    @(negedge clk);
    valid_s = 1'b0;
    flush = 1'b0;
    check1("flush_drops_accept", s_valid, 1'b0);

    // ---- MUL 7 * -3 completes while downstream stalls ----
    dready = 1'b0;
    drive(1'b1, 3'b000, ADD, 32'd7, 32'hFFFF_FFFD, 32'h0000_0300, 5'd11);
    @(negedge clk);
    valid_s = 1'b0;
    j = 0;
    while (!s_valid && j < 60) begin
      @(negedge clk);
      j++;
    end
    check1("mul_valid", s_valid, 1'b1);
    check32("mul_result", s_result, 32'hFFFF_FFEB);
    held = s_result;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (!s_valid || s_result !== held || s_pc !== 32'h0000_0300 ||
          s_regdst !== 5'd11 || s_ready) bad++;
    end
    check32("stall_hold_violations", 32'(bad), 32'd0);
    dready = 1'b1;
    #1;
    check1("ready_follows_downstream", s_ready, 1'b1);
    @(negedge clk);
    check1("stall_release_valid_falls", s_valid, 1'b0);

    // ---- asynchronous reset in the middle of a DIV ----
    drive(1'b1, 3'b100, ADD, 32'd100, 32'd7, 32'h0000_0500, 5'd9);
    @(negedge clk);
    valid_s = 1'b0;
    repeat (5) @(negedge clk);
    check1("pre_reset_busy", s_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check1("midrst_valid", s_valid, 1'b0);
    check1("midrst_busy", s_busy, 1'b0);
    check32("midrst_result", s_result, 32'h0);
    check32("midrst_pc", s_pc, 32'h0);
    check32("midrst_regdst", {27'd0, s_regdst}, 32'h0);
    check1("midrst_ready", s_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_quick("post_reset_or", 1'b0, 3'b000, OR_, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
